// File: rtl/calc_data_stack_pkg.sv
// Shared constants and types for the calculator operand stack.
// Number width/zero and stack geometry live here so the stack and its
// storage agree on one definition.
package calc_data_stack_pkg;

  // Width of one calculator number and its zero value.
  localparam int              CD_N = 16;
  localparam logic [CD_N-1:0] CD_0 = '0;

  // Default stack geometry: depth and count width ($clog2(depth)+1).
  localparam int DS_DEPTH = 8;
  localparam int DS_CNT_N = 4;

  // Stack operation requested in a cycle, before full/empty qualification.
  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_REPL = 2'd3   // push+pop together: overwrite the top entry
  } stk_op_e;

  // Map the push/pop strobes onto an operation code.
  function automatic stk_op_e f_decode_op(input logic push, input logic pop);
    stk_op_e op;
    case ({push, pop})
      2'b10:   op = OP_PUSH;
      2'b01:   op = OP_POP;
      2'b11:   op = OP_REPL;
      default: op = OP_HOLD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/calc_lifo_mem.sv
// DEPTH x DATA_W register file backing the operand stack.
// One synchronous write port, two asynchronous read ports (top and
// second-from-top). A read of the address being written returns the old
// contents until the edge.
module calc_lifo_mem #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              Clock,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr0,
  input  logic [AW-1:0]     raddr1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1
);

  logic [DEPTH-1:0][DATA_W-1:0] r_mem;

  // Single write port; contents are not reset (validity is tracked by count).
  always_ff @(posedge Clock) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata0 = r_mem[raddr0];
  assign rdata1 = r_mem[raddr1];

endmodule

// File: rtl/calc_data_stack.sv
// LIFO operand stack for the calculator controller.
// Holds the entry count and sticky overflow/underflow flags, decodes
// reset > clear > push/pop priority, and gates the two read ports to zero
// when the addressed entry is not valid.
module calc_data_stack
  import calc_data_stack_pkg::*;
#(
  parameter int DATA_W = CD_N,
  parameter int DEPTH  = DS_DEPTH,
  parameter int CNT_W  = DS_CNT_N
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              dt_push,
  input  logic              dt_pop,
  input  logic              dt_clear,
  input  logic [DATA_W-1:0] dt_din,
  output logic [DATA_W-1:0] dt_data,
  output logic [DATA_W-1:0] dt_data2,
  output logic              dt_empty,
  output logic              dt_full,
  output logic [CNT_W-1:0]  dt_count,
  output logic              dt_ovf,
  output logic              dt_udf
);

  localparam int               AW      = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [CNT_W-1:0]  r_count;
  logic              r_ovf;
  logic              r_udf;

  stk_op_e           w_op;
  logic              w_empty;
  logic              w_full;
  logic [AW-1:0]     w_top_addr;
  logic [AW-1:0]     w_sec_addr;
  logic              w_we_dec;
  logic              w_we;
  logic [AW-1:0]     w_waddr;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_ovf_set;
  logic              w_udf_set;
  logic [DATA_W-1:0] w_rd_top;
  logic [DATA_W-1:0] w_rd_sec;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == DEPTH_C);

  // Pointer arithmetic is modulo DEPTH: at count==DEPTH the low bits are 0,
  // so count-1 wraps to DEPTH-1, which is exactly the top slot.
  assign w_top_addr = r_count[AW-1:0] - AW'(1);
  assign w_sec_addr = r_count[AW-1:0] - AW'(2);

  // Qualify the requested op against full/empty to get write, next count and flag sets.
  always_comb begin
    w_op      = f_decode_op(dt_push, dt_pop);
    w_we_dec  = 1'b0;
    w_waddr   = r_count[AW-1:0];
    w_cnt_nxt = r_count;
    w_ovf_set = 1'b0;
    w_udf_set = 1'b0;
    case (w_op)
      OP_PUSH: begin
        if (!w_full) begin
          w_we_dec  = 1'b1;
          w_cnt_nxt = r_count + 1'b1;
        end else begin
          w_ovf_set = 1'b1;
        end
      end
      OP_POP: begin
        if (!w_empty) w_cnt_nxt = r_count - 1'b1;
        else          w_udf_set = 1'b1;
      end
      OP_REPL: begin
        // Replace-top is legal even when full; only an empty stack faults.
        if (!w_empty) begin
          w_we_dec = 1'b1;
          w_waddr  = w_top_addr;
        end else begin
          w_udf_set = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Reset and clear both suppress the memory write so no stale entry moves.
  assign w_we = w_we_dec & Reset & ~dt_clear;

  // Count and sticky flags: reset > clear > qualified push/pop.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else if (dt_clear) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      r_count <= w_cnt_nxt;
      if (w_ovf_set) r_ovf <= 1'b1;
      if (w_udf_set) r_udf <= 1'b1;
    end
  end

  calc_lifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .Clock  (Clock),
    .we     (w_we),
    .waddr  (w_waddr),
    .wdata  (dt_din),
    .raddr0 (w_top_addr),
    .raddr1 (w_sec_addr),
    .rdata0 (w_rd_top),
    .rdata1 (w_rd_sec)
  );

  assign dt_data  = !w_empty              ? w_rd_top : DATA_W'(CD_0);
  assign dt_data2 = (r_count >= CNT_W'(2)) ? w_rd_sec : DATA_W'(CD_0);
  assign dt_empty = w_empty;
  assign dt_full  = w_full;
  assign dt_count = r_count;
  assign dt_ovf   = r_ovf;
  assign dt_udf   = r_udf;

endmodule

// File: tb/tb_calc_data_stack.sv
// Bench for calc_data_stack: a queue-based reference stack predicts the
// post-edge outputs of every cycle; predictions and DUT samples are queued
// and drained by each scenario task, with a few spot checks against fixed values.
module tb_calc_data_stack;
  import calc_data_stack_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        dt_push, dt_pop, dt_clear;
  logic [15:0] dt_din;
  logic [15:0] dt_data, dt_data2;
  logic        dt_empty, dt_full, dt_ovf, dt_udf;
  logic [3:0]  dt_count;

  always #5 Clock = ~Clock;

  calc_data_stack #(.DATA_W(16), .DEPTH(8), .CNT_W(4)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .dt_push  (dt_push),
    .dt_pop   (dt_pop),
    .dt_clear (dt_clear),
    .dt_din   (dt_din),
    .dt_data  (dt_data),
    .dt_data2 (dt_data2),
    .dt_empty (dt_empty),
    .dt_full  (dt_full),
    .dt_count (dt_count),
    .dt_ovf   (dt_ovf),
    .dt_udf   (dt_udf)
  );

  typedef struct packed {
    logic [15:0] d;
    logic [15:0] d2;
    logic        e;
    logic        f;
    logic [3:0]  c;
    logic        o;
    logic        u;
  } snap_t;

  snap_t       exp_q[$];
  snap_t       obs_q[$];
  logic [15:0] stk[$];
  bit          m_ovf, m_udf;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic snap_t model_snap();
    snap_t s;
    int    n = stk.size();
    s.d  = (n >= 1) ? stk[n-1] : 16'd0;
    s.d2 = (n >= 2) ? stk[n-2] : 16'd0;
    s.e  = (n == 0);
    s.f  = (n == 8);
    s.c  = 4'(n);
    s.o  = m_ovf;
    s.u  = m_udf;
    return s;
  endfunction

  function automatic snap_t dut_snap();
    return {dt_data, dt_data2, dt_empty, dt_full, dt_count, dt_ovf, dt_udf};
  endfunction

  // Drive one cycle, advance the reference stack, queue prediction and sample.
  task automatic cyc(input logic rst, input logic clr, input logic psh,
                     input logic pp, input logic [15:0] din);
    Reset = rst; dt_clear = clr; dt_push = psh; dt_pop = pp; dt_din = din;
    if (!rst || clr) begin
      stk.delete(); m_ovf = 0; m_udf = 0;
    end else if (psh && !pp) begin
      if (stk.size() < 8) stk.push_back(din); else m_ovf = 1;
    end else if (pp && !psh) begin
      if (stk.size() > 0) void'(stk.pop_back()); else m_udf = 1;
    end else if (psh && pp) begin
      if (stk.size() > 0) stk[stk.size()-1] = din; else m_udf = 1;
    end
    exp_q.push_back(model_snap());
    @(posedge Clock);
    #1;
    obs_q.push_back(dut_snap());
  endtask

  task automatic test_reset();
    snap_t e, o;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL reset_seq: got %h want %h", o, e); end
    end
    n_cmp++;
    if (dt_empty !== 1'b1 || dt_count !== 4'd0 || dt_data !== 16'd0 || dt_ovf !== 1'b0 || dt_udf !== 1'b0) begin
      n_bad++; $display("FAIL reset_idle: got e=%b c=%0d d=%h o=%b u=%b want 1 0 0000 0 0", dt_empty, dt_count, dt_data, dt_ovf, dt_udf);
    end
  endtask

  task automatic test_push_pop();
    snap_t e, o;
    cyc(1, 0, 1, 0, 16'd5);
    cyc(1, 0, 1, 0, 16'd7);
    cyc(1, 0, 1, 0, 16'd9);
    n_cmp++;
    if (dt_data !== 16'd9 || dt_data2 !== 16'd7 || dt_count !== 4'd3) begin
      n_bad++; $display("FAIL push3: got d=%0d d2=%0d c=%0d want 9 7 3", dt_data, dt_data2, dt_count);
    end
    cyc(1, 0, 0, 1, 16'd0);
    n_cmp++;
    if (dt_data !== 16'd7 || dt_data2 !== 16'd5) begin
      n_bad++; $display("FAIL pop1: got d=%0d d2=%0d want 7 5", dt_data, dt_data2);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL push_pop_seq: got %h want %h", o, e); end
    end
  endtask

  task automatic test_fill_ovf();
    snap_t e, o;
    cyc(1, 1, 0, 0, 0);
    for (int i = 1; i <= 8; i++) cyc(1, 0, 1, 0, 16'(i));
    cyc(1, 0, 1, 0, 16'd99);
    n_cmp++;
    if (dt_count !== 4'd8 || dt_full !== 1'b1 || dt_ovf !== 1'b1 || dt_data !== 16'd8) begin
      n_bad++; $display("FAIL ovf: got c=%0d f=%b o=%b d=%0d want 8 1 1 8", dt_count, dt_full, dt_ovf, dt_data);
    end
    cyc(1, 0, 1, 1, 16'd42);
    n_cmp++;
    if (dt_data !== 16'd42 || dt_count !== 4'd8 || dt_ovf !== 1'b1 || dt_data2 !== 16'd7) begin
      n_bad++; $display("FAIL repl_full: got d=%0d c=%0d o=%b d2=%0d want 42 8 1 7", dt_data, dt_count, dt_ovf, dt_data2);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL fill_seq: got %h want %h", o, e); end
    end
  endtask

  task automatic test_udf();
    snap_t e, o;
    cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 1, 1, 16'd3);
    n_cmp++;
    if (dt_udf !== 1'b1 || dt_count !== 4'd0 || dt_data !== 16'd0) begin
      n_bad++; $display("FAIL udf: got u=%b c=%0d d=%0d want 1 0 0", dt_udf, dt_count, dt_data);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL udf_seq: got %h want %h", o, e); end
    end
  endtask

  task automatic test_clear();
    snap_t e, o;
    cyc(1, 0, 0, 1, 0);           // still empty: sets udf
    cyc(1, 0, 1, 0, 16'd21);
    cyc(1, 0, 1, 0, 16'd22);
    cyc(1, 0, 1, 0, 16'd23);
    cyc(1, 1, 1, 0, 16'd11);
    n_cmp++;
    if (dt_count !== 4'd0 || dt_empty !== 1'b1 || dt_ovf !== 1'b0 || dt_udf !== 1'b0 || dt_data !== 16'd0) begin
      n_bad++; $display("FAIL clear: got c=%0d e=%b o=%b u=%b d=%0d want 0 1 0 0 0", dt_count, dt_empty, dt_ovf, dt_udf, dt_data);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL clear_seq: got %h want %h", o, e); end
    end
  endtask

  task automatic test_reset_mid();
    snap_t e, o;
    cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 16'd4);
    cyc(1, 0, 1, 0, 16'd6);
    cyc(0, 0, 1, 0, 16'd8);
    n_cmp++;
    if (dt_count !== 4'd0) begin
      n_bad++; $display("FAIL reset_mid: got c=%0d want 0", dt_count);
    end
    cyc(1, 0, 1, 0, 16'd2);
    n_cmp++;
    if (dt_data !== 16'd2 || dt_data2 !== 16'd0) begin
      n_bad++; $display("FAIL after_reset: got d=%0d d2=%0d want 2 0", dt_data, dt_data2);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL reset_mid_seq: got %h want %h", o, e); end
    end
  endtask

  task automatic test_random();
    snap_t e, o;
    for (int i = 0; i < 400; i++) begin
      int r = $urandom_range(0, 99);
      logic psh = ($urandom_range(0, 99) < 60);
      logic pp  = ($urandom_range(0, 99) < 45);
      cyc((r != 99), (r < 2), psh, pp, 16'($urandom));
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL random_seq: got %h want %h", o, e); end
    end
  endtask

  initial begin
    Reset = 0; dt_push = 0; dt_pop = 0; dt_clear = 0; dt_din = '0;
    test_reset();
    test_push_pop();
    test_fill_ovf();
    test_udf();
    test_clear();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
